jzjpcc_muldiv_scheduler: RTL and testbench

//  Sequences the shared multi-cycle multiply/divide unit for RV32M ops in execute.

---
 rtl/jzjpcc_muldiv_scheduler.sv | 129 ++++++++++++
 tb/tb_jzjpcc_muldiv_scheduler.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/jzjpcc_muldiv_scheduler.sv
// Sequencer for the shared multi-cycle RV32M multiply/divide unit in execute.
// It starts the unit, counts its fixed latency, stalls the front end and flags pending-rd hazards.
module jzjpcc_muldiv_scheduler #(
  parameter int unsigned MUL_LATENCY = 3,
  parameter int unsigned DIV_LATENCY = 32,
  parameter int unsigned CNT_W       = 6
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       opValid_execute,
  input  logic       opIsDiv_execute,
  input  logic [4:0] rdAddr_execute,
  input  logic       flush_execute,
  input  logic [4:0] rs1Addr_decode,
  input  logic [4:0] rs2Addr_decode,
  output logic       unitStart,
  output logic       unitIsDiv,
  output logic       stall_execute,
  output logic       resultValid,
  output logic [4:0] resultRdAddr,
  output logic       resultRegWrite,
  output logic       rawHazard_decode
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LATENCY - 32'd1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LATENCY - 32'd1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  function automatic logic has_dest(input logic [4:0] rd);
    return (rd != 5'd0);
  endfunction

  function automatic logic reads_rd(input logic [4:0] rs1, input logic [4:0] rs2,
                                    input logic [4:0] rd);
    return has_dest(rd) && ((rs1 == rd) || (rs2 == rd));
  endfunction

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [4:0]       rd_q, rd_d;
  logic             is_div_q, is_div_d;

  logic             start_s;
  logic             stall_s;
  logic             valid_s;
  logic [CNT_W-1:0] load_s;

  // State, latency counter and latched op fields.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      count_q  <= CNT_ZERO;
      rd_q     <= 5'd0;
      is_div_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      rd_q     <= rd_d;
      is_div_q <= is_div_d;
    end
  end

  // Next-state logic; the counter is loaded only from IDLE and stops at one.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    rd_d     = rd_q;
    is_div_d = is_div_q;
    start_s  = 1'b0;
    stall_s  = 1'b0;
    valid_s  = 1'b0;
    load_s   = opIsDiv_execute ? DIV_LOAD : MUL_LOAD;
    case (state_q)
      ST_IDLE: begin
        if (opValid_execute && !flush_execute) begin
          start_s  = 1'b1;
          stall_s  = 1'b1;
          rd_d     = rdAddr_execute;
          is_div_d = opIsDiv_execute;
          count_d  = load_s;
          state_d  = (load_s == CNT_ZERO) ? ST_DONE : ST_BUSY;
        end else begin
          count_d  = CNT_ZERO;
          state_d  = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (flush_execute) begin
          state_d = ST_IDLE;
          count_d = CNT_ZERO;
        end else if (count_q <= CNT_ONE) begin
          stall_s = 1'b1;
          state_d = ST_DONE;
          count_d = CNT_ZERO;
        end else begin
          stall_s = 1'b1;
          state_d = ST_BUSY;
          count_d = count_q - CNT_ONE;
        end
      end
      ST_DONE: begin
        valid_s = !flush_execute;
        state_d = ST_IDLE;
        count_d = CNT_ZERO;
      end
      default: begin
        state_d = ST_IDLE;
        count_d = CNT_ZERO;
      end
    endcase
  end

  // Start and stall depend on the live op, so they are also held low while reset is asserted.
  assign unitStart        = start_s & reset_n;
  assign stall_execute    = stall_s & reset_n;
  assign resultValid      = valid_s;
  assign resultRegWrite   = valid_s & has_dest(rd_q);
  assign unitIsDiv        = is_div_q;
  assign resultRdAddr     = rd_q;
  assign rawHazard_decode = (state_q == ST_BUSY) & reads_rd(rs1Addr_decode, rs2Addr_decode, rd_q);

endmodule

// File: tb/tb_jzjpcc_muldiv_scheduler.sv
// Bench for jzjpcc_muldiv_scheduler: directed table, multi-cycle sequences and a
// randomized run against a time-based transaction model.
module tb_jzjpcc_muldiv_scheduler;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       op_valid, op_is_div, flush;
  logic [4:0] rd, rs1, rs2;
  logic       u_start, u_is_div, stall, r_valid, r_we, haz;
  logic [4:0] r_rd;

  logic       op_valid2, op_is_div2, flush2;
  logic [4:0] rd2, rs12, rs22;
  logic       u_start2, u_is_div2, stall2, r_valid2, r_we2, haz2;
  logic [4:0] r_rd2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  jzjpcc_muldiv_scheduler dut (
    .clock(clock), .reset_n(reset_n),
    .opValid_execute(op_valid), .opIsDiv_execute(op_is_div), .rdAddr_execute(rd),
    .flush_execute(flush), .rs1Addr_decode(rs1), .rs2Addr_decode(rs2),
    .unitStart(u_start), .unitIsDiv(u_is_div), .stall_execute(stall),
    .resultValid(r_valid), .resultRdAddr(r_rd), .resultRegWrite(r_we),
    .rawHazard_decode(haz)
  );

  jzjpcc_muldiv_scheduler #(.MUL_LATENCY(1)) dut_l1 (
    .clock(clock), .reset_n(reset_n),
    .opValid_execute(op_valid2), .opIsDiv_execute(op_is_div2), .rdAddr_execute(rd2),
    .flush_execute(flush2), .rs1Addr_decode(rs12), .rs2Addr_decode(rs22),
    .unitStart(u_start2), .unitIsDiv(u_is_div2), .stall_execute(stall2),
    .resultValid(r_valid2), .resultRdAddr(r_rd2), .resultRegWrite(r_we2),
    .rawHazard_decode(haz2)
  );

  typedef struct {
    logic       v, d;
    logic [4:0] rd;
    logic       f;
    logic [4:0] r1, r2;
    logic       e_start, e_stall, e_valid, e_div;
    logic [4:0] e_rd;
    logic       e_we, e_haz;
  } vec_t;

  vec_t tbl[27];

  function automatic vec_t mk(input logic v, input logic d, input logic [4:0] r,
                              input logic f, input logic [4:0] r1, input logic [4:0] r2,
                              input logic st, input logic sl, input logic va,
                              input logic dv, input logic [4:0] er, input logic we,
                              input logic hz);
    vec_t t;
    t.v = v; t.d = d; t.rd = r; t.f = f; t.r1 = r1; t.r2 = r2;
    t.e_start = st; t.e_stall = sl; t.e_valid = va; t.e_div = dv;
    t.e_rd = er; t.e_we = we; t.e_haz = hz;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic d, input logic [4:0] r,
                       input logic f, input logic [4:0] r1, input logic [4:0] r2);
    op_valid = v; op_is_div = d; rd = r; flush = f; rs1 = r1; rs2 = r2;
  endtask

  task automatic check_all(input string tag, input logic st, input logic sl, input logic va,
                           input logic dv, input logic [4:0] er, input logic we,
                           input logic hz);
    chk({tag, ".start"}, 32'(u_start), 32'(st));
    chk({tag, ".stall"}, 32'(stall),   32'(sl));
    chk({tag, ".valid"}, 32'(r_valid), 32'(va));
    chk({tag, ".isdiv"}, 32'(u_is_div), 32'(dv));
    chk({tag, ".rd"},    32'(r_rd),    32'(er));
    chk({tag, ".we"},    32'(r_we),    32'(we));
    chk({tag, ".haz"},   32'(haz),     32'(hz));
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  // Reference model state for the randomized phase
  int         cyc;
  bit         m_active;
  int         m_start_cyc, m_lat, pos;
  logic [4:0] m_rd;
  logic       m_div;
  logic       e_start, e_stall, e_valid, e_we, e_haz;

  initial begin
    reset_n = 1'b0;
    drive(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0);
    op_valid2 = 1'b0; op_is_div2 = 1'b0; rd2 = 5'd0; flush2 = 1'b0; rs12 = 5'd0; rs22 = 5'd0;
    #1;
    check_all("reset", 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;

    tbl[0]  = mk(1,0,5,0,5,0, 1,1,0,0,5'd0,0,0);
    tbl[1]  = mk(1,0,5,0,5,0, 0,1,0,0,5'd5,0,1);
    tbl[2]  = mk(1,0,5,0,5,0, 0,1,0,0,5'd5,0,1);
    tbl[3]  = mk(1,0,5,0,5,0, 0,0,1,0,5'd5,1,0);
    tbl[4]  = mk(0,0,0,0,0,0, 0,0,0,0,5'd5,0,0);
    tbl[5]  = mk(1,0,0,0,0,0, 1,1,0,0,5'd5,0,0);
    tbl[6]  = mk(1,0,0,0,0,0, 0,1,0,0,5'd0,0,0);
    tbl[7]  = mk(1,0,0,0,0,0, 0,1,0,0,5'd0,0,0);
    tbl[8]  = mk(1,0,0,0,0,0, 0,0,1,0,5'd0,0,0);
    tbl[9]  = mk(1,0,3,0,9,3, 1,1,0,0,5'd0,0,0);
    tbl[10] = mk(1,0,3,0,9,3, 0,1,0,0,5'd3,0,1);
    tbl[11] = mk(1,0,3,0,9,3, 0,1,0,0,5'd3,0,1);
    tbl[12] = mk(1,0,3,0,9,3, 0,0,1,0,5'd3,1,0);
    tbl[13] = mk(1,0,4,0,4,0, 1,1,0,0,5'd3,0,0);
    tbl[14] = mk(1,0,4,1,4,0, 0,0,0,0,5'd4,0,1);
    tbl[15] = mk(0,0,0,0,0,0, 0,0,0,0,5'd4,0,0);
    tbl[16] = mk(1,0,8,1,0,0, 0,0,0,0,5'd4,0,0);
    tbl[17] = mk(0,0,0,0,0,0, 0,0,0,0,5'd4,0,0);
    tbl[18] = mk(1,0,6,0,0,0, 1,1,0,0,5'd4,0,0);
    tbl[19] = mk(1,0,6,0,0,0, 0,1,0,0,5'd6,0,0);
    tbl[20] = mk(1,0,6,0,0,0, 0,1,0,0,5'd6,0,0);
    tbl[21] = mk(1,0,6,1,0,0, 0,0,0,0,5'd6,0,0);
    tbl[22] = mk(1,0,2,0,0,0, 1,1,0,0,5'd6,0,0);
    tbl[23] = mk(1,0,2,0,0,0, 0,1,0,0,5'd2,0,0);
    tbl[24] = mk(1,0,2,0,0,0, 0,1,0,0,5'd2,0,0);
    tbl[25] = mk(1,0,2,0,0,0, 0,0,1,0,5'd2,1,0);
    tbl[26] = mk(0,0,0,0,0,0, 0,0,0,0,5'd2,0,0);

    for (int i = 0; i < 27; i++) begin
      drive(tbl[i].v, tbl[i].d, tbl[i].rd, tbl[i].f, tbl[i].r1, tbl[i].r2);
      @(negedge clock);
      check_all($sformatf("tbl%0d", i), tbl[i].e_start, tbl[i].e_stall, tbl[i].e_valid,
                tbl[i].e_div, tbl[i].e_rd, tbl[i].e_we, tbl[i].e_haz);
      next_cycle();
    end

    // DIV rd=7: 32-cycle stall, hazard on rs2, masked window with rs1=rs2=6
    for (int k = 0; k <= 32; k++) begin
      drive(1'b1, 1'b1, 5'd7, 1'b0, 5'd6, (k >= 10 && k < 12) ? 5'd6 : 5'd7);
      @(negedge clock);
      check_all($sformatf("div%0d", k), k == 0, k < 32, k == 32, k >= 1,
                (k == 0) ? 5'd2 : 5'd7, k == 32, (k >= 1 && k <= 31 && !(k >= 10 && k < 12)));
      next_cycle();
    end

    // Flush at BUSY cycle 4 of a DIV, then a MUL one cycle later
    for (int k = 0; k <= 9; k++) begin
      if (k <= 4)      drive(1'b1, 1'b1, 5'd12, k == 4, 5'd0, 5'd0);
      else if (k == 5) drive(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0);
      else             drive(1'b1, 1'b0, 5'd9, 1'b0, 5'd0, 5'd0);
      @(negedge clock);
      chk($sformatf("fl%0d.start", k), 32'(u_start), 32'(k == 0 || k == 6));
      chk($sformatf("fl%0d.stall", k), 32'(stall), 32'(k < 4 || (k >= 6 && k <= 8)));
      chk($sformatf("fl%0d.valid", k), 32'(r_valid), 32'(k == 9));
      if (k == 9) chk("fl.rd", 32'(r_rd), 32'd9);
      next_cycle();
    end
    drive(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0);
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      chk("fl.quiet", 32'(r_valid | stall), 32'd0);
      next_cycle();
    end

    // MUL_LATENCY=1 build: back-to-back starts every second cycle
    op_valid2 = 1'b1; rd2 = 5'd1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      chk($sformatf("l1_%0d.start", k), 32'(u_start2), 32'(k % 2 == 0));
      chk($sformatf("l1_%0d.stall", k), 32'(stall2), 32'(k % 2 == 0));
      chk($sformatf("l1_%0d.valid", k), 32'(r_valid2), 32'(k % 2 == 1));
      if (k % 2 == 1) chk("l1.we", 32'(r_we2), 32'd1);
      next_cycle();
    end
    op_valid2 = 1'b0;

    // Asynchronous reset mid-BUSY with count=10
    drive(1'b1, 1'b1, 5'd7, 1'b0, 5'd0, 5'd7);
    repeat (22) @(posedge clock);
    #1;
    chk("rst.busy_stall", 32'(stall), 32'd1);
    chk("rst.busy_haz", 32'(haz), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check_all("rst.async", 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    next_cycle();
    reset_n = 1'b1;
    drive(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd7);
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      chk("rst.quiet", 32'({r_valid, stall, haz}), 32'd0);
      next_cycle();
    end

    // Randomized run against the transaction model
    cyc = 0; m_active = 1'b0; m_start_cyc = 0; m_lat = 0; m_rd = 5'd0; m_div = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      drive(($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
            ($urandom_range(0, 19) == 0),
            ($urandom_range(0, 2) == 0) ? m_rd : 5'($urandom),
            ($urandom_range(0, 2) == 0) ? m_rd : 5'($urandom));
      e_start = 1'b0; e_stall = 1'b0; e_valid = 1'b0; e_we = 1'b0; e_haz = 1'b0;
      pos = cyc - m_start_cyc;
      if (!m_active) begin
        e_start = op_valid && !flush;
        e_stall = e_start;
      end else if (pos < m_lat) begin
        e_stall = !flush;
        e_haz   = (m_rd != 5'd0) && (rs1 == m_rd || rs2 == m_rd);
      end else begin
        e_valid = !flush;
        e_we    = e_valid && (m_rd != 5'd0);
      end
      @(negedge clock);
      check_all($sformatf("rnd%0d", n), e_start, e_stall, e_valid, m_div, m_rd, e_we, e_haz);
      next_cycle();
      if (!m_active) begin
        if (e_start) begin
          m_active = 1'b1; m_start_cyc = cyc; m_lat = op_is_div ? 32 : 3;
          m_rd = rd; m_div = op_is_div;
        end
      end else if (pos >= m_lat || flush) begin
        m_active = 1'b0;
      end
      cyc++;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
